// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit engine among NREQ byte requesters.
// Latency: req seen at edge n from IDLE -> load/ack in cycle n+1; back-to-back load one cycle after a txrdy rise.
// Backpressure: a grant is held until the engine's txrdy rises; requesters keep req high until they see ack.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-low reset
//   req, lock     per-requester level request and burst lock
//   data          flattened bytes, requester i at data[8*i+7:8*i]
//   txrdy         engine ready flag; only a 0->1 edge ends a frame
//   load, ack     single-cycle pulses in the LOAD cycle (ack is one-hot)
//   out_port      registered byte to the engine, stable until the next load
//   grant         one-hot owner of the engine, held from load until the frame completes
//   busy          high in LOAD and WAIT
// Optional feature: define UART_TX_ARB_LOCK_EN so that a locked requester keeps the engine
// across back-to-back frames. Without it, lock is ignored.
module uart_tx_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*8-1:0] data,
  input  logic              txrdy,
  output logic              load,
  output logic [7:0]        out_port,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            txrdy_q;
  logic            txrdy_rise;
  logic            any_req;
  logic            take;
  logic            release_grant;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] winner_oh;

  // A level-high txrdy left over from an earlier frame must not end WAIT,
  // so the frame only completes on a fresh rising edge.
  assign txrdy_rise    = txrdy & ~txrdy_q;
  assign any_req       = |req;
  assign take          = any_req & ((state == S_IDLE) | ((state == S_WAIT) & txrdy_rise));
  assign release_grant = (state == S_WAIT) & txrdy_rise & ~any_req;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    // A locked burst keeps the engine, but only on a back-to-back handover;
    // a selection from IDLE is always plain round-robin.
    if ((state == S_WAIT) && req[ptr] && lock[ptr]) begin
      winner = ptr;
    end
`endif
  end

`ifndef UART_TX_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (txrdy_rise) begin
          state_nxt = any_req ? S_LOAD : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Selection bookkeeping and the registered byte/grant. txrdy_q is sampled
  // every cycle so the edge detector tracks the engine regardless of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txrdy_q  <= 1'b0;
      ptr      <= PW'(NREQ - 1);
      grant    <= '0;
      out_port <= '0;
    end else begin
      txrdy_q <= txrdy;
      if (take) begin
        ptr      <= winner;
        grant    <= winner_oh;
        out_port <= data[{winner, 3'b000} +: 8];
      end else if (release_grant) begin
        grant <= '0;
      end
    end
  end

  // Outputs decoded from the state register; grant already equals onehot(ptr)
  // in LOAD, so ack is just the grant gated by the LOAD cycle.
  always_comb begin
    load = 1'b0;
    ack  = '0;
    busy = 1'b0;
    if (state == S_LOAD) begin
      load = 1'b1;
      ack  = grant;
    end
    if (state != S_IDLE) begin
      busy = 1'b1;
    end
  end

endmodule
